// File: rtl/mode_counter.sv
// -----------------------------------------------------------------------------
// mode_counter
//   Up/down counter with programmable step and inclusive modulus [0, mod_max].
//   Supports wrap or saturate at the range boundaries. Produces a one-cycle
//   terminal-count pulse and a sticky boundary-event flag. Used as a general
//   timebase or event counter.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset (clears all state)
//   load       : synchronous load of cnt_in (clipped to mod_max); highest priority
//   enab       : count enable
//   up_dn      : 1 = count up, 0 = count down
//   sat_mode   : 1 = saturate at the boundary, 0 = wrap
//   step       : unsigned increment/decrement applied per enabled cycle
//   mod_max    : inclusive upper bound of the count range
//   cnt_in     : load value
//   clr_ovf    : synchronous clear of ovf_sticky (a same-edge event wins)
//   cnt_out    : registered count
//   tc         : registered pulse, high in the cycle after a boundary event
//   ovf_sticky : registered sticky boundary-event flag
// -----------------------------------------------------------------------------
module mode_counter #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              enab,
   input  logic              up_dn,
   input  logic              sat_mode,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  mod_max,
   input  logic [WIDTH-1:0]  cnt_in,
   input  logic              clr_ovf,
   output logic [WIDTH-1:0]  cnt_out,
   output logic              tc,
   output logic              ovf_sticky
);

   // Two guard bits keep mod_max+1 and cnt+step free of overflow, even when
   // mod_max is all-ones.
   localparam int EW = WIDTH + 2;

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             evt;

   logic [EW-1:0] cnt_e, step_e, mod_e, mod_p1, sum_e;

   assign cnt_e  = EW'(cnt_q);
   assign step_e = EW'(step);
   assign mod_e  = EW'(mod_max);
   assign mod_p1 = mod_e + EW'(1);
   assign sum_e  = cnt_e + step_e;

   always_comb begin
      cnt_d = cnt_q;
      evt   = 1'b0;
      if (load) begin
         cnt_d = (cnt_in <= mod_max) ? cnt_in : mod_max;
      end else if (enab && (step_e != '0)) begin
         if (cnt_e > mod_e) begin
            // The count is stranded above a modulus that was lowered at runtime.
            evt   = 1'b1;
            cnt_d = sat_mode ? mod_max : '0;
         end else if (up_dn) begin
            if (sum_e <= mod_e) begin
               cnt_d = WIDTH'(sum_e);
            end else begin
               evt = 1'b1;
               if (sat_mode)
                  cnt_d = mod_max;
               else if (step_e <= mod_p1)
                  cnt_d = WIDTH'(sum_e - mod_p1);
               else
                  cnt_d = '0;
            end
         end else begin
            if (step_e <= cnt_e) begin
               cnt_d = WIDTH'(cnt_e - step_e);
            end else begin
               evt = 1'b1;
               if (sat_mode)
                  cnt_d = '0;
               else if (step_e <= mod_p1)
                  cnt_d = WIDTH'(cnt_e + mod_p1 - step_e);
               else
                  cnt_d = '0;
            end
         end
      end
   end

   always_comb begin
      tc_d  = evt;
      ovf_d = ovf_q;
      // A boundary event on the same edge as clr_ovf keeps the flag set.
      if (evt)
         ovf_d = 1'b1;
      else if (clr_ovf)
         ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_out    = cnt_q;
   assign tc         = tc_q;
   assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_mode_counter.sv
module tb_mode_counter;
   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              load, enab, up_dn, sat_mode, clr_ovf;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  mod_max, cnt_in;
   logic [WIDTH-1:0]  cnt_out;
   logic              tc, ovf_sticky;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   int m_cnt = 0;
   bit m_tc  = 0;
   bit m_ovf = 0;

   always #5 clk = ~clk;

   mode_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk(clk), .rst(rst), .load(load), .enab(enab), .up_dn(up_dn),
      .sat_mode(sat_mode), .step(step), .mod_max(mod_max), .cnt_in(cnt_in),
      .clr_ovf(clr_ovf), .cnt_out(cnt_out), .tc(tc), .ovf_sticky(ovf_sticky)
   );

   // Behavioural model: range is [0, m], wrapping is arithmetic modulo m+1.
   task automatic model_edge();
      int c, m, s, n;
      bit ev;
      c = m_cnt; m = int'(mod_max); s = int'(step); n = c; ev = 0;
      if (load) n = (int'(cnt_in) > m) ? m : int'(cnt_in);
      else if (enab && s != 0) begin
         if (c > m) begin ev = 1; n = sat_mode ? m : 0; end
         else if (up_dn) begin
            if (c + s <= m) n = c + s;
            else begin ev = 1; n = sat_mode ? m : ((s <= m + 1) ? (c + s) % (m + 1) : 0); end
         end else begin
            if (s <= c) n = c - s;
            else begin ev = 1; n = sat_mode ? 0 : ((s <= m + 1) ? (c - s + m + 1) % (m + 1) : 0); end
         end
      end
      m_cnt = n;
      m_tc  = ev;
      m_ovf = ev ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
   endtask

   // Advance one edge; inputs were set at the previous negedge, outputs are
   // observed at the following negedge.
   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      load = 0; enab = 0; clr_ovf = 0;
   endtask

   task automatic do_load(input int v);
      idle(); load = 1; cnt_in = WIDTH'(v);
      tick();
      idle();
   endtask

   task automatic test_reset();
      rst = 0; idle(); up_dn = 1; sat_mode = 0; step = 1; mod_max = 9; cnt_in = 0;
      @(negedge clk); @(negedge clk);
      n_chk++; if (cnt_out !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt_out); end
      n_chk++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b expected 0", tc); end
      n_chk++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_sticky); end
      rst = 1;
      tick();
      n_chk++; if (cnt_out !== 8'd0) begin n_fail++; $display("FAIL reset_release_cnt: got %0d expected 0", cnt_out); end
   endtask

   task automatic test_wrap_up();
      mod_max = 9; sat_mode = 0; up_dn = 1; step = 1; enab = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_chk++; if (cnt_out !== WIDTH'((i + 1) % 10)) begin n_fail++; $display("FAIL wrap_up_cnt[%0d]: got %0d expected %0d", i, cnt_out, (i + 1) % 10); end
         n_chk++; if (tc !== (i == 9)) begin n_fail++; $display("FAIL wrap_up_tc[%0d]: got %b expected %b", i, tc, i == 9); end
         n_chk++; if (ovf_sticky !== (i >= 9)) begin n_fail++; $display("FAIL wrap_up_ovf[%0d]: got %b expected %b", i, ovf_sticky, i >= 9); end
      end
      idle();
   endtask

   task automatic test_sat_up();
      logic [7:0] exp_c [3];
      bit         exp_t [3];
      exp_c[0] = 253; exp_c[1] = 255; exp_c[2] = 255;
      exp_t[0] = 0;   exp_t[1] = 1;   exp_t[2] = 1;
      mod_max = 255; sat_mode = 1; up_dn = 1; step = 3;
      do_load(250);
      n_chk++; if (cnt_out !== 8'd250) begin n_fail++; $display("FAIL sat_load: got %0d expected 250", cnt_out); end
      enab = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++; if (cnt_out !== exp_c[i]) begin n_fail++; $display("FAIL sat_up_cnt[%0d]: got %0d expected %0d", i, cnt_out, exp_c[i]); end
         n_chk++; if (tc !== exp_t[i]) begin n_fail++; $display("FAIL sat_up_tc[%0d]: got %b expected %b", i, tc, exp_t[i]); end
      end
      idle();
      tick();
      n_chk++; if (tc !== 1'b0 || cnt_out !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got cnt=%0d tc=%b expected cnt=255 tc=0", cnt_out, tc); end
   endtask

   task automatic test_down();
      mod_max = 9; sat_mode = 0; up_dn = 0; step = 4;
      do_load(2);
      enab = 1; tick(); idle();
      n_chk++; if (cnt_out !== 8'd8 || tc !== 1'b1) begin n_fail++; $display("FAIL down_wrap: got cnt=%0d tc=%b expected cnt=8 tc=1", cnt_out, tc); end
      sat_mode = 1;
      do_load(2);
      n_chk++; if (tc !== 1'b0) begin n_fail++; $display("FAIL down_load_tc: got %b expected 0", tc); end
      enab = 1; tick(); idle();
      n_chk++; if (cnt_out !== 8'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL down_sat: got cnt=%0d tc=%b expected cnt=0 tc=1", cnt_out, tc); end
   endtask

   task automatic test_load();
      mod_max = 9; sat_mode = 0; up_dn = 1; step = 1;
      load = 1; enab = 1; cnt_in = 5; tick(); idle();
      n_chk++; if (cnt_out !== 8'd5 || tc !== 1'b0) begin n_fail++; $display("FAIL load_priority: got cnt=%0d tc=%b expected cnt=5 tc=0", cnt_out, tc); end
      do_load(20);
      n_chk++; if (cnt_out !== 8'd9) begin n_fail++; $display("FAIL load_clip: got %0d expected 9", cnt_out); end
   endtask

   task automatic test_mod_change();
      mod_max = 9; sat_mode = 0; up_dn = 1; step = 1;
      do_load(7);
      mod_max = 4; enab = 1; tick(); idle();
      n_chk++; if (cnt_out !== 8'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL mod_drop: got cnt=%0d tc=%b expected cnt=0 tc=1", cnt_out, tc); end
   endtask

   task automatic test_sticky();
      clr_ovf = 1; tick(); idle();
      n_chk++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clear1: got %b expected 0", ovf_sticky); end
      mod_max = 9; sat_mode = 1; up_dn = 1; step = 1;
      do_load(9);
      enab = 1; clr_ovf = 1; tick(); idle();
      n_chk++; if (ovf_sticky !== 1'b1 || tc !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins: got ovf=%b tc=%b expected ovf=1 tc=1", ovf_sticky, tc); end
      tick();
      n_chk++; if (ovf_sticky !== 1'b1 || tc !== 1'b0) begin n_fail++; $display("FAIL sticky_hold: got ovf=%b tc=%b expected ovf=1 tc=0", ovf_sticky, tc); end
      clr_ovf = 1; tick(); idle();
      n_chk++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clear2: got %b expected 0", ovf_sticky); end
   endtask

   task automatic test_async_reset();
      mod_max = 9; sat_mode = 0; up_dn = 1; step = 3;
      do_load(8);
      enab = 1; tick();   // 8+3 > 9 -> wraps to 1, event
      n_chk++; if (cnt_out !== 8'd1 || ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got cnt=%0d ovf=%b expected cnt=1 ovf=1", cnt_out, ovf_sticky); end
      #2 rst = 0;
      #1;
      n_chk++; if (cnt_out !== 8'd0 || tc !== 1'b0 || ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL async_reset: got cnt=%0d tc=%b ovf=%b expected 0 0 0", cnt_out, tc, ovf_sticky); end
      m_cnt = 0; m_tc = 0; m_ovf = 0;
      idle();
      @(negedge clk);
      rst = 1;
      tick();
      n_chk++; if (cnt_out !== 8'd0 || tc !== 1'b0) begin n_fail++; $display("FAIL post_reset_hold: got cnt=%0d tc=%b expected 0 0", cnt_out, tc); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         load     = ($urandom_range(0, 9) == 0);
         enab     = ($urandom_range(0, 3) != 0);
         clr_ovf  = ($urandom_range(0, 9) == 0);
         up_dn    = $urandom_range(0, 1);
         sat_mode = $urandom_range(0, 1);
         step     = STEP_W'($urandom_range(0, 15));
         mod_max  = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom_range(0, 15)) :
                    (($urandom_range(0, 4) == 0) ? WIDTH'(255) : WIDTH'($urandom_range(0, 255)));
         cnt_in   = WIDTH'($urandom_range(0, 255));
         tick();
         n_chk++; if (int'(cnt_out) !== m_cnt) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, cnt_out, m_cnt); end
         n_chk++; if (tc !== m_tc) begin n_fail++; $display("FAIL rand_tc[%0d]: got %b expected %b", i, tc, m_tc); end
         n_chk++; if (ovf_sticky !== m_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b expected %b", i, ovf_sticky, m_ovf); end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_sat_up();
      test_down();
      test_load();
      test_mod_change();
      test_sticky();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
- Parametrised up/down counter; next generation of the team's loadable enable counter.
- Adds: direction control, programmable step and modulus, wrap or saturate mode, a terminal-count pulse, and a sticky overflow flag.
- Used as a general timebase/event counter in datapath and control blocks.
- All state is updated on the rising edge of clk.

Parameters:
- WIDTH, 8: counter width in bits (>=2).
- STEP_W, 4: width of the step input in bits (1..WIDTH).

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset. Assertion (0) clears all state immediately, independent of clk.
- load  input  1  synchronous load of cnt_in.
- enab  input  1  count enable.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap.
- step  input  STEP_W  unsigned increment/decrement per enabled cycle.
- mod_max  input  WIDTH  inclusive upper bound of the count range [0, mod_max].
- cnt_in  input  WIDTH  load value.
- clr_ovf  input  1  synchronous clear of ovf_sticky.
- cnt_out  output  WIDTH  registered count.
- tc  output  1  registered one-cycle terminal-count/boundary pulse.
- ovf_sticky  output  1  registered sticky boundary-event flag.

Behaviour:
- Reset (rst=0): cnt_out=0, tc=0, ovf_sticky=0. Reset is asynchronous and overrides everything. Deassertion takes effect at the next clk edge; no count occurs on the deassertion edge itself unless enab/load are set at that edge.
- Priority at each clk edge: load > enab > hold.

Load:
- cnt_out <= cnt_in if cnt_in <= mod_max, else mod_max.
- No event is flagged. tc=0 in that cycle.

Enable, no load:
- step=0: hold, no event.
- Out of range (cnt_out > mod_max, e.g. mod_max lowered at runtime), either direction: next = 0 in wrap mode, mod_max in saturate mode. Event flagged.
- Up, cnt_out + step <= mod_max: next = cnt_out + step. No event.
- Up, sum > mod_max, event flagged:
  - wrap: next = cnt_out + step - (mod_max+1) when step <= mod_max+1; otherwise next = 0.
  - sat: next = mod_max. This includes holding at mod_max; every enabled cycle at the limit flags an event.
- Down, step <= cnt_out: next = cnt_out - step. No event.
- Down, step > cnt_out, event flagged:
  - wrap: next = cnt_out + (mod_max+1) - step when step <= mod_max+1; otherwise next = 0.
  - sat: next = 0.

Arithmetic and outputs:
- All intermediate arithmetic is done at WIDTH+2 bits, so mod_max+1 never overflows (mod_max = all-ones gives the full 2^WIDTH range).
- step is zero-extended to WIDTH.
- Latency: one cycle. tc and the cnt_out update appear together after the triggering edge.
- tc = 1 for exactly the cycle following an edge that flagged an event, else 0. Back-to-back events give tc held high.
- ovf_sticky: set on an event edge. Cleared on an edge with clr_ovf=1 and no event. If an event and clr_ovf occur on the same edge, set wins.
- Hold (enab=0, load=0): all state retained; tc=0.
- Inputs up_dn, sat_mode, step and mod_max may change on any cycle and are sampled at the clk edge.

Test Plan:
- WIDTH=8, mod_max=9, wrap, up, step=1, cnt from 0, enab held 12 cycles -> cnt_out 1..9,0,1,2. tc high only the cycle cnt_out returns to 0. ovf_sticky=1 from that cycle on.
- mod_max=255, sat, up, step=3, load 250 then enable 3 cycles -> 253, 255, 255. tc=1 on the last two cycles.
- Down, wrap, mod_max=9, step=4, load 2, enable once -> cnt_out=8, tc pulse. Then sat mode, load 2, enable -> cnt_out=0, tc pulse.
- Load priority and load clipping:
  - load=1 and enab=1 together with cnt_in=5 -> cnt_out=5, tc=0.
  - cnt_in=20 with mod_max=9 -> cnt_out=9.
- Runtime modulus change: cnt_out=7, mod_max dropped to 4, enab, wrap -> cnt_out=0, tc=1.
- Sticky flag and reset:
  - clr_ovf together with an event keeps ovf_sticky=1.
  - clr_ovf alone clears ovf_sticky the next cycle.
  - rst pulsed low mid-count between edges -> cnt_out, tc, ovf_sticky go 0 immediately.
